// File: rtl/mult_acc_pkg.sv
// Shared types and default parameters for the block multiply-accumulator.
package mult_acc_pkg;

    localparam int unsigned PROD_WIDTH_DEF = 7;
    localparam int unsigned ACC_WIDTH_DEF  = 10;
    localparam int unsigned BLOCK_LEN_DEF  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/acc_out_reg.sv
// Result holding register with valid/ready handshake and a sticky flag for lost results.
module acc_out_reg #(
    parameter int unsigned ACC_WIDTH = mult_acc_pkg::ACC_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [ACC_WIDTH-1:0] data,
    input  logic                 acc_ready,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 acc_valid,
    output logic                 overflow_err
);

    logic slot_free_c;

    // The slot can take a new result if empty or being drained this cycle.
    assign slot_free_c = !acc_valid || acc_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc          <= '0;
            acc_valid    <= 1'b0;
            overflow_err <= 1'b0;
        end else if (load) begin
            if (slot_free_c) begin
                acc       <= data;
                acc_valid <= 1'b1;
            end else begin
                overflow_err <= 1'b1;
            end
        end else if (acc_valid && acc_ready) begin
            acc_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mult_accumulator.sv
// Sums BLOCK_LEN unsigned products per result and presents each sum through a handshake register.
// Define MULT_ACCUMULATOR_SATURATE_EN to clamp the running sum instead of wrapping.
module mult_accumulator
    import mult_acc_pkg::*;
#(
    parameter int unsigned PROD_WIDTH = PROD_WIDTH_DEF,
    parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int unsigned BLOCK_LEN  = BLOCK_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PROD_WIDTH-1:0] z,
    input  logic                  z_valid,
    output logic [ACC_WIDTH-1:0]  acc,
    output logic                  acc_valid,
    input  logic                  acc_ready,
    output logic                  overflow_err
);

    localparam int unsigned CNT_WIDTH = $clog2(BLOCK_LEN + 1);

    state_t                state_q, state_d;
    logic [ACC_WIDTH-1:0]  sum_q, sum_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [ACC_WIDTH-1:0]  z_ext_c;
    logic [ACC_WIDTH-1:0]  sum_add_c;
    logic                  last_c;

    assign z_ext_c = ACC_WIDTH'(z);
    assign last_c  = z_valid && (count_q == CNT_WIDTH'(BLOCK_LEN - 1));

`ifdef MULT_ACCUMULATOR_SATURATE_EN
    logic [ACC_WIDTH:0] sum_full_c;

    // Carry out of the add means the true sum no longer fits: clamp to all-ones.
    assign sum_full_c = {1'b0, sum_q} + {1'b0, z_ext_c};
    assign sum_add_c  = sum_full_c[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_full_c[ACC_WIDTH-1:0];
`else
    assign sum_add_c = sum_q + z_ext_c;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sum_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            count_q <= count_d;
        end
    end

    // Next-state and datapath update; the final product of a block restarts from zero.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        count_d = count_q;

        case (state_q)
            IDLE: if (z_valid) state_d = RUN;
            RUN:  if (last_c)  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (z_valid) begin
            if (last_c) begin
                sum_d   = '0;
                count_d = '0;
            end else begin
                sum_d   = sum_add_c;
                count_d = count_q + CNT_WIDTH'(1);
            end
        end
    end

    acc_out_reg #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_acc_out_reg (
        .clk          (clk),
        .rst          (rst),
        .load         (last_c),
        .data         (sum_add_c),
        .acc_ready    (acc_ready),
        .acc          (acc),
        .acc_valid    (acc_valid),
        .overflow_err (overflow_err)
    );

endmodule
